// File: rtl/pipe_sub_pkg.sv
// pipe_sub_pkg: shared widths and stage payload types for the pipelined subtractor
package pipe_sub_pkg;
    localparam int DW = 32;
    localparam int HW = 16;
    // Everything S2 needs to finish the upper half and the flags
    typedef struct packed {
        logic [HW-1:0] d_lo;
        logic          c16;
        logic [HW-1:0] a_hi;
        logic [HW-1:0] nb_hi;
        logic          a_msb;
        logic          b_msb;
    } s1_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          bo;
        logic          ov;
        logic          z;
    } s2_t;
endpackage

// File: rtl/pipe_sub_32bits_if.sv
// pipe_sub_32bits_if: operand/result valid-ready bus of the subtractor
// master: producer/consumer side; slave: the subtractor
interface pipe_sub_32bits_if;
    logic                       in_valid;
    logic                       in_ready;
    logic [pipe_sub_pkg::DW-1:0] a;
    logic [pipe_sub_pkg::DW-1:0] b;
    logic                       bi;
    logic                       out_valid;
    logic                       out_ready;
    logic [pipe_sub_pkg::DW-1:0] d;
    logic                       bo;
    logic                       ov;
    logic                       z;
    modport master (output in_valid, a, b, bi, out_ready, input in_ready, out_valid, d, bo, ov, z);
    modport slave (input in_valid, a, b, bi, out_ready, output in_ready, out_valid, d, bo, ov, z);
endinterface

// File: rtl/pipe_sub_32bits_cla16_slice.sv
// cla16_slice: 16-bit two-level carry-lookahead adder
// x, y: addends; cin: carry-in; s: sum; cout: carry out of bit 15
module cla16_slice (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;
    logic        cc;
    always_comb begin
        p = x ^ y;
        g = x & y;
        for (int i = 0; i < 4; i++) begin
            gp[i] = &p[4*i +: 4];
            gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (&p[4*i+2 +: 2] & g[4*i+1]) | (&p[4*i+1 +: 3] & g[4*i]);
        end
        // second-level lookahead: group carries directly from cin
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (&gp[1:0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (&gp[2:1] & gg[0]) | (&gp[2:0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (&gp[3:2] & gg[1]) | (&gp[3:1] & gg[0]) | (&gp[3:0] & cin);
        for (int i = 0; i < 4; i++) begin
            cc = gc[i];
            for (int j = 0; j < 4; j++) begin
                c[4*i+j] = cc;
                cc = g[4*i+j] | (p[4*i+j] & cc);
            end
        end
        s = p ^ c;
        cout = gc[4];
    end
endmodule

// File: rtl/pipe_sub_32bits.sv
// pipe_sub_32bits: two-stage pipelined d = a - b - bi with borrow, overflow and zero flags
// clk, rst (async, active-high); bus: slave side of pipe_sub_32bits_if
module pipe_sub_32bits
    import pipe_sub_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pipe_sub_32bits_if.slave   bus
);
    logic          s1_v, s2_v, s1_adv, s2_adv;
    s1_t           s1_q, s1_n;
    s2_t           s2_q, s2_n;
    logic [HW-1:0] lo_s, hi_s;
    logic          lo_c, hi_c;
    logic [DW-1:0] d_full;
    // subtraction as a + ~b + ~bi
    cla16_slice u_lo (.x(bus.a[HW-1:0]), .y(~bus.b[HW-1:0]), .cin(~bus.bi), .s(lo_s), .cout(lo_c));
    cla16_slice u_hi (.x(s1_q.a_hi), .y(s1_q.nb_hi), .cin(s1_q.c16), .s(hi_s), .cout(hi_c));
    assign s2_adv = ~s2_v | bus.out_ready;
    assign s1_adv = ~s1_v | s2_adv;
    assign d_full = {hi_s, s1_q.d_lo};
    assign s1_n = '{d_lo: lo_s, c16: lo_c, a_hi: bus.a[DW-1:HW], nb_hi: ~bus.b[DW-1:HW],
                    a_msb: bus.a[DW-1], b_msb: bus.b[DW-1]};
    assign s2_n = '{d: d_full, bo: ~hi_c, ov: (s1_q.a_msb ^ s1_q.b_msb) & (hi_s[HW-1] ^ s1_q.a_msb),
                    z: ~|d_full};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= bus.in_valid;
                s1_q <= s1_n;
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                s2_q <= s2_n;
            end
        end
    end
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v;
    assign bus.d         = s2_q.d;
    assign bus.bo        = s2_q.bo;
    assign bus.ov        = s2_q.ov;
    assign bus.z         = s2_q.z;
endmodule
